// File: rtl/mod_counter_casc_if.sv
// mod_counter_casc_if: control/data bundle for one counter stage; CMP/MATCH only with MOD_COUNTER_CASC_MATCH_EN.
interface mod_counter_casc_if #(parameter int WIDTH = 4);
    logic             LOAD_N;
    logic             ENP;
    logic             ENT;
    logic             UP;
    logic [WIDTH-1:0] PRE;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             WRAP;
`ifdef MOD_COUNTER_CASC_MATCH_EN
    logic [WIDTH-1:0] CMP;
    logic             MATCH;
    modport master (output LOAD_N, ENP, ENT, UP, PRE, CMP, input Q, RCO, WRAP, MATCH);
    modport slave  (input LOAD_N, ENP, ENT, UP, PRE, CMP, output Q, RCO, WRAP, MATCH);
`else
    modport master (output LOAD_N, ENP, ENT, UP, PRE, input Q, RCO, WRAP);
    modport slave  (input LOAD_N, ENP, ENT, UP, PRE, output Q, RCO, WRAP);
`endif
endinterface

// File: rtl/mod_counter_casc.sv
// mod_counter_casc: presettable modulo-MODULUS up/down counter with ENP/ENT cascade, RCO and WRAP strobe.
// Optional registered compare strobe MATCH enabled by MOD_COUNTER_CASC_MATCH_EN.
module mod_counter_casc #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic              CLK,
    input logic              CLR,
    mod_counter_casc_if.slave bus
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_wrap;
    logic             w_tc;
    logic             w_cnt;
    always_comb begin
        w_tc    = bus.UP ? (r_q == LAST) : (r_q == '0);
        w_cnt   = bus.LOAD_N & bus.ENP & bus.ENT;
        // out-of-range presets saturate so Q never leaves 0..MODULUS-1
        w_q_nxt = !bus.LOAD_N ? ((bus.PRE > LAST) ? LAST : bus.PRE) :
                  !w_cnt      ? r_q :
                  bus.UP      ? (w_tc ? '0 : r_q + 1'b1) :
                                (w_tc ? LAST : r_q - 1'b1);
    end
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_cnt & w_tc;
        end
    end
    assign bus.Q    = r_q;
    assign bus.RCO  = bus.ENT & w_tc;
    assign bus.WRAP = r_wrap;
`ifdef MOD_COUNTER_CASC_MATCH_EN
    logic r_match;
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) r_match <= 1'b0;
        else      r_match <= (w_q_nxt == bus.CMP);
    end
    assign bus.MATCH = r_match;
`endif
endmodule

// File: tb/tb_mod_counter_casc.sv
// tb_mod_counter_casc: directed checks of a MODULUS=10 stage and a two-stage decade cascade.
module tb_mod_counter_casc;
    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;
    int   hi_wraps;
    int   e;

    mod_counter_casc_if #(.WIDTH(4)) d_if ();
    mod_counter_casc_if #(.WIDTH(4)) lo_if ();
    mod_counter_casc_if #(.WIDTH(4)) hi_if ();

    mod_counter_casc #(.WIDTH(4), .MODULUS(10)) u_dut (.CLK(clk), .CLR(clr), .bus(d_if.slave));
    mod_counter_casc #(.WIDTH(4), .MODULUS(10)) u_lo  (.CLK(clk), .CLR(clr), .bus(lo_if.slave));
    mod_counter_casc #(.WIDTH(4), .MODULUS(10)) u_hi  (.CLK(clk), .CLR(clr), .bus(hi_if.slave));

    assign hi_if.ENT = lo_if.RCO;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; hi_wraps = 0;
        clr = 1'b0;
        d_if.LOAD_N = 1'b1; d_if.ENP = 1'b0; d_if.ENT = 1'b0; d_if.UP = 1'b1; d_if.PRE = '0;
        lo_if.LOAD_N = 1'b1; lo_if.ENP = 1'b0; lo_if.ENT = 1'b0; lo_if.UP = 1'b1; lo_if.PRE = '0;
        hi_if.LOAD_N = 1'b1; hi_if.ENP = 1'b1; hi_if.UP = 1'b1; hi_if.PRE = '0;
`ifdef MOD_COUNTER_CASC_MATCH_EN
        d_if.CMP = 4'd7; lo_if.CMP = '0; hi_if.CMP = '0;
`endif
        #2;
        chk("rst_q", d_if.Q, 0);
        chk("rst_wrap", d_if.WRAP, 0);
        chk("rst_rco_ent0", d_if.RCO, 0);
        d_if.ENT = 1'b1; d_if.UP = 1'b0; #1;
        chk("rst_rco_down", d_if.RCO, 1);
        d_if.UP = 1'b1; #1;
        chk("rst_rco_up", d_if.RCO, 0);
`ifdef MOD_COUNTER_CASC_MATCH_EN
        chk("rst_match", d_if.MATCH, 0);
`endif
        #8 clr = 1'b1;
        d_if.ENP = 1'b1;
        tick(); tick(); tick();
        chk("pre_clr_q", d_if.Q, 3);
        clr = 1'b0; #1;
        chk("clr_q", d_if.Q, 0);
        chk("clr_wrap", d_if.WRAP, 0);
        #2 clr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = (i + 1) % 10;
            chk("up_q", d_if.Q, e);
            chk("up_wrap", d_if.WRAP, (e == 0) ? 1 : 0);
            chk("up_rco", d_if.RCO, (e == 9) ? 1 : 0);
        end
        d_if.LOAD_N = 1'b0; d_if.PRE = 4'd1;
        tick();
        chk("ld1_q", d_if.Q, 1);
        chk("ld1_wrap", d_if.WRAP, 0);
        d_if.LOAD_N = 1'b1; d_if.UP = 1'b0;
        tick();
        chk("dn_q0", d_if.Q, 0);
        chk("dn_rco0", d_if.RCO, 1);
        chk("dn_wrap0", d_if.WRAP, 0);
        tick();
        chk("dn_q9", d_if.Q, 9);
        chk("dn_wrap9", d_if.WRAP, 1);
        chk("dn_rco9", d_if.RCO, 0);
        tick();
        chk("dn_q8", d_if.Q, 8);
        chk("dn_wrap8", d_if.WRAP, 0);
        d_if.LOAD_N = 1'b0; d_if.PRE = 4'd9; d_if.UP = 1'b1;
        tick();
        chk("ld9_q", d_if.Q, 9);
        d_if.PRE = 4'd12;
        tick();
        chk("ld_sat_q", d_if.Q, 9);
        chk("ld_prio_wrap", d_if.WRAP, 0);
        d_if.PRE = 4'd15;
        tick();
        chk("ld_sat15_q", d_if.Q, 9);
        d_if.PRE = 4'd3;
        tick();
        chk("ld3_q", d_if.Q, 3);
        d_if.PRE = 4'd9;
        tick();
        d_if.LOAD_N = 1'b1; d_if.ENP = 1'b0;
        tick();
        chk("enp0_q", d_if.Q, 9);
        chk("enp0_rco", d_if.RCO, 1);
        chk("enp0_wrap", d_if.WRAP, 0);
        d_if.ENP = 1'b1; d_if.ENT = 1'b0;
        tick();
        chk("ent0_q", d_if.Q, 9);
        chk("ent0_rco", d_if.RCO, 0);
        lo_if.ENP = 1'b1; lo_if.ENT = 1'b1;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (hi_if.WRAP) hi_wraps++;
        end
        chk("casc37_lo", lo_if.Q, 7);
        chk("casc37_hi", hi_if.Q, 3);
        for (int i = 0; i < 63; i++) begin
            tick();
            if (hi_if.WRAP) hi_wraps++;
        end
        chk("casc100_lo", lo_if.Q, 0);
        chk("casc100_hi", hi_if.Q, 0);
        chk("casc_hi_wraps", hi_wraps, 1);
        lo_if.ENP = 1'b0; lo_if.ENT = 1'b0;
`ifdef MOD_COUNTER_CASC_MATCH_EN
        d_if.ENT = 1'b1; d_if.UP = 1'b1;
        clr = 1'b0; #2 clr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            e = (i + 1) % 10;
            chk("match_q", d_if.Q, e);
            chk("match", d_if.MATCH, (e == 7) ? 1 : 0);
        end
        for (int i = 0; i < 7; i++) tick();
        chk("match_pre_clr", d_if.MATCH, 1);
        clr = 1'b0; #1;
        chk("match_clr", d_if.MATCH, 0);
        #2 clr = 1'b1;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
